// File: rtl/tester_pkg.sv
// Shared constants and types for the part_tester command sequencer:
// command bytes, ASCII reply characters, FSM encodings and the debug view.
package tester_pkg;

  // Command bytes: 'r','s','g','i','o','e','f','p'
  localparam logic [7:0] CMD_RESET       = 8'h72;
  localparam logic [7:0] CMD_SET_STATE   = 8'h73;
  localparam logic [7:0] CMD_GET_STATE   = 8'h67;
  localparam logic [7:0] CMD_SET_INPUTS  = 8'h69;
  localparam logic [7:0] CMD_GET_OUTPUTS = 8'h6F;
  localparam logic [7:0] CMD_EXECUTE     = 8'h65;
  localparam logic [7:0] CMD_FREE_RUN    = 8'h66;
  localparam logic [7:0] CMD_PAUSE       = 8'h70;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [3:0] {
    BANNER, IDLE, LEN_HI, LEN_LO, SET_ST, GET_ST, SET_IN, GET_OUT, EXEC, FREE, RESET
  } state_e;

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT} tx_ph_e;

  typedef struct packed {
    state_e state;
    tx_ph_e tx_ph;
    logic   pc_wait;
    logic   pc_busy;
    logic   buf_valid;
  } dbg_t;

  function automatic logic [7:0] ascii_bit(input logic b);
    return ASCII_0 | {7'b0, b};
  endfunction

endpackage

// File: rtl/part_clk_gen.sv
// One part clock cycle per start pulse: part_clk low CLK_DIV clks, high
// CLK_DIV clks, then a one-clk done pulse. part_clk idles low.
module part_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic part_clk
);

  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam logic [CW-1:0] LOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(2 * CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          pclk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pclk_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q && start) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
        pclk_q <= 1'b0;
      end else if (busy_q) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LOW_LAST) pclk_q <= 1'b1;
        if (cnt_q == HIGH_LAST) begin
          busy_q <= 1'b0;
          pclk_q <= 1'b0;
          done_q <= 1'b1;
          cnt_q  <= '0;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign part_clk = pclk_q;

endmodule

// File: rtl/tester_cmd_sequencer.sv
// UART command sequencer for part_tester: parses byte commands with 16-bit
// lengths and drives scan/inputs/clocking of the part, replying in ASCII.
module tester_cmd_sequencer
  import tester_pkg::*;
#(
  parameter int NPIS    = 14,
  parameter int NPOS    = 11,
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  input  logic            tx_ready,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  output logic            part_clk,
  output logic            part_rstn,
  output logic            part_se,
  output logic            part_tm,
  output logic            part_si,
  input  logic            part_so,
  output logic [NPIS-1:0] part_pis,
  input  logic [NPOS-1:0] part_pos,
  output logic            idle,
  output logic            err,
  output dbg_t            dbg
);

  state_e          state_q, state_d;
  tx_ph_e          tx_ph_q, tx_ph_d;
  logic [1:0]      sub_q, sub_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      len_hi_q, len_hi_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     idx_q, idx_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            pc_wait_q, pc_wait_d;
  logic            pause_q, pause_d;
  logic            rstn_q, rstn_d;
  logic            se_q, se_d;
  logic            si_q, si_d;
  logic [NPIS-1:0] pis_q, pis_d;
  logic [NPOS-1:0] shadow_q, shadow_d;
  logic            buf_valid_q, buf_valid_d;
  logic [7:0]      buf_data_q, buf_data_d;
  logic            err_q, err_d;

  logic        pc_start, pc_busy, pc_done;
  logic        tx_req, tx_done;
  logic [7:0]  tx_byte;
  logic        in_valid, in_is_bit, byte_rdy, take, pc_fin, pause_now, out_bit;
  logic [7:0]  in_byte;
  logic [15:0] n_len;

  part_clk_gen #(.CLK_DIV(CLK_DIV)) u_pclk (
    .clk      (clk),
    .rst      (rst),
    .start    (pc_start),
    .busy     (pc_busy),
    .done     (pc_done),
    .part_clk (part_clk)
  );

  always_comb begin
    state_d     = state_q;
    tx_ph_d     = tx_ph_q;
    sub_d       = sub_q;
    cmd_d       = cmd_q;
    len_hi_d    = len_hi_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tx_start_d  = tx_start_q;
    tx_data_d   = tx_data_q;
    pc_wait_d   = pc_wait_q;
    pause_d     = pause_q;
    rstn_d      = rstn_q;
    se_d        = se_q;
    si_d        = si_q;
    pis_d       = pis_q;
    shadow_d    = shadow_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    err_d       = 1'b0;
    pc_start    = 1'b0;
    tx_req      = 1'b0;
    tx_byte     = 8'h00;

    // A held byte is always consumed before the one on rx_data.
    in_valid  = buf_valid_q | rx_valid;
    in_byte   = buf_valid_q ? buf_data_q : rx_data;
    in_is_bit = (in_byte == ASCII_0) || (in_byte == ASCII_1);
    byte_rdy  = (state_q inside {IDLE, LEN_HI, LEN_LO, SET_IN}) ||
                (state_q == SET_ST && !pc_wait_q);
    take      = byte_rdy && in_valid;
    tx_done   = (tx_ph_q == TX_WAIT) && tx_ready;
    pc_fin    = pc_wait_q && pc_done;
    pause_now = rx_valid && (rx_data == CMD_PAUSE);
    n_len     = {len_hi_q, in_byte};
    if (pc_fin) pc_wait_d = 1'b0;

    out_bit = 1'b0;
    for (int k = 0; k < NPOS; k++) begin
      if (idx_q == 16'(k)) out_bit = shadow_q[k];
    end

    case (state_q)
      BANNER: begin
        rstn_d  = 1'b1;
        tx_req  = 1'b1;
        tx_byte = (sub_q == 2'd0) ? ASCII_O : (sub_q == 2'd1) ? ASCII_K : ASCII_LF;
        if (tx_done) begin
          if (sub_q == 2'd2) begin
            sub_d   = 2'd0;
            state_d = IDLE;
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
      end
      IDLE: begin
        if (take) begin
          case (in_byte)
            CMD_RESET: begin
              sub_d   = 2'd0;
              state_d = RESET;
            end
            CMD_SET_STATE, CMD_GET_STATE, CMD_SET_INPUTS, CMD_GET_OUTPUTS, CMD_EXECUTE: begin
              cmd_d   = in_byte;
              state_d = LEN_HI;
            end
            CMD_FREE_RUN: begin
              pause_d = 1'b0;
              state_d = FREE;
            end
            CMD_PAUSE: begin
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      LEN_HI: begin
        if (take) begin
          len_hi_d = in_byte;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (take) begin
          cnt_d = n_len;
          idx_d = 16'd0;
          if (cmd_q == CMD_GET_OUTPUTS) shadow_d = part_pos;
          if (n_len == 16'd0) begin
            state_d = IDLE;
          end else begin
            case (cmd_q)
              CMD_SET_STATE:   state_d = SET_ST;
              CMD_GET_STATE:   state_d = GET_ST;
              CMD_SET_INPUTS:  state_d = SET_IN;
              CMD_GET_OUTPUTS: state_d = GET_OUT;
              CMD_EXECUTE:     state_d = EXEC;
              default:         state_d = IDLE;
            endcase
          end
        end
      end
      SET_ST: begin
        if (take) begin
          if (in_is_bit) begin
            si_d      = in_byte[0];
            se_d      = 1'b1;
            pc_start  = 1'b1;
            pc_wait_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (pc_fin) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            se_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end
      GET_ST: begin
        if (!pc_wait_q) begin
          tx_req  = 1'b1;
          tx_byte = ascii_bit(part_so);
          // Feeding part_so back into part_si rotates the chain in place.
          if (tx_done) begin
            se_d      = 1'b1;
            si_d      = part_so;
            pc_start  = 1'b1;
            pc_wait_d = 1'b1;
          end
        end else if (pc_fin) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            se_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end
      SET_IN: begin
        if (take) begin
          if (in_is_bit) begin
            for (int k = 0; k < NPIS; k++) begin
              if (idx_q == 16'(k)) pis_d[k] = in_byte[0];
            end
            idx_d = idx_q + 16'd1;
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GET_OUT: begin
        tx_req  = 1'b1;
        tx_byte = ascii_bit(out_bit);
        if (tx_done) begin
          idx_d = idx_q + 16'd1;
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = IDLE;
        end
      end
      EXEC: begin
        se_d = 1'b0;
        if (!pc_wait_q) begin
          pc_start  = 1'b1;
          pc_wait_d = 1'b1;
        end else if (pc_fin) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = IDLE;
        end
      end
      FREE: begin
        se_d = 1'b0;
        if (pause_now) pause_d = 1'b1;
        if (!pc_wait_q) begin
          if (pause_q || pause_now) begin
            pause_d = 1'b0;
            state_d = IDLE;
          end else begin
            pc_start  = 1'b1;
            pc_wait_d = 1'b1;
          end
        end else if (pc_fin && (pause_q || pause_now)) begin
          pause_d = 1'b0;
          state_d = IDLE;
        end
      end
      RESET: begin
        rstn_d = 1'b0;
        pis_d  = '0;
        se_d   = 1'b0;
        if (!pc_wait_q) begin
          pc_start  = 1'b1;
          pc_wait_d = 1'b1;
        end else if (pc_fin) begin
          if (sub_q == 2'd1) begin
            sub_d   = 2'd0;
            rstn_d  = 1'b1;
            state_d = BANNER;
          end else begin
            sub_d = 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // One-entry hold buffer; a byte arriving while it is full is dropped.
    if (state_q inside {IDLE, LEN_HI, LEN_LO, SET_ST, SET_IN}) begin
      if (take) begin
        if (buf_valid_q) begin
          buf_valid_d = rx_valid;
          buf_data_d  = rx_data;
        end
      end else if (rx_valid) begin
        if (!buf_valid_q) begin
          buf_valid_d = 1'b1;
          buf_data_d  = rx_data;
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      buf_valid_d = 1'b0;
    end

    // tx_start is held until tx_ready drops; the byte completes when tx_ready returns.
    case (tx_ph_q)
      TX_IDLE: begin
        if (tx_req && tx_ready) begin
          tx_start_d = 1'b1;
          tx_data_d  = tx_byte;
          tx_ph_d    = TX_REQ;
        end
      end
      TX_REQ: begin
        if (!tx_ready) begin
          tx_start_d = 1'b0;
          tx_ph_d    = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tx_ready) tx_ph_d = TX_IDLE;
      end
      default: tx_ph_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BANNER;
      tx_ph_q     <= TX_IDLE;
      sub_q       <= 2'd0;
      cmd_q       <= 8'h00;
      len_hi_q    <= 8'h00;
      cnt_q       <= 16'd0;
      idx_q       <= 16'd0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      pc_wait_q   <= 1'b0;
      pause_q     <= 1'b0;
      rstn_q      <= 1'b0;
      se_q        <= 1'b0;
      si_q        <= 1'b0;
      pis_q       <= '0;
      shadow_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_ph_q     <= tx_ph_d;
      sub_q       <= sub_d;
      cmd_q       <= cmd_d;
      len_hi_q    <= len_hi_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      pc_wait_q   <= pc_wait_d;
      pause_q     <= pause_d;
      rstn_q      <= rstn_d;
      se_q        <= se_d;
      si_q        <= si_d;
      pis_q       <= pis_d;
      shadow_q    <= shadow_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      err_q       <= err_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign part_rstn = rstn_q;
  assign part_se   = se_q;
  assign part_tm   = se_q;
  assign part_si   = si_q;
  assign part_pis  = pis_q;
  assign idle      = (state_q == IDLE);
  assign err       = err_q;

  assign dbg.state     = state_q;
  assign dbg.tx_ph     = tx_ph_q;
  assign dbg.pc_wait   = pc_wait_q;
  assign dbg.pc_busy   = pc_busy;
  assign dbg.buf_valid = buf_valid_q;

endmodule

// File: tb/tb_tester_cmd_sequencer.sv
// Directed bench for tester_cmd_sequencer with a UART tx model and a
// 4-bit scan chain model looped from part_si to part_so.
module tb_tester_cmd_sequencer;
  import tester_pkg::*;

  localparam int NPIS    = 14;
  localparam int NPOS    = 11;
  localparam int CLK_DIV = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            tx_ready = 1'b1;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            part_clk, part_rstn, part_se, part_tm, part_si, part_so;
  logic [NPIS-1:0] part_pis;
  logic [NPOS-1:0] part_pos = 11'h5A5;
  logic            idle, err;
  dbg_t            dbg;

  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  tester_cmd_sequencer #(.NPIS(NPIS), .NPOS(NPOS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .part_clk(part_clk), .part_rstn(part_rstn), .part_se(part_se), .part_tm(part_tm),
    .part_si(part_si), .part_so(part_so), .part_pis(part_pis), .part_pos(part_pos),
    .idle(idle), .err(err), .dbg(dbg)
  );

  // ---------------- environment models ----------------
  logic [7:0] tx_log [0:255];
  int         tx_cnt = 0;
  int         tx_busy = 0;

  always @(negedge clk) begin
    if (tx_busy > 0) begin
      tx_busy = tx_busy - 1;
      if (tx_busy == 0) tx_ready = 1'b1;
    end else if (tx_start && tx_ready) begin
      tx_log[tx_cnt % 256] = tx_data;
      tx_cnt   = tx_cnt + 1;
      tx_ready = 1'b0;
      tx_busy  = 3;
    end
  end

  logic [3:0] sr = 4'b0000;
  logic       si_log [0:1023];
  int         edge_cnt = 0;
  int         se0_cnt = 0;
  assign part_so = sr[3];

  always @(posedge part_clk) begin
    if (part_se) sr <= {sr[2:0], part_si};
    si_log[edge_cnt % 1024] <= part_si;
    edge_cnt <= edge_cnt + 1;
    if (!part_se) se0_cnt <= se0_cnt + 1;
  end

  int err_cnt = 0;
  int hi_run = 0;
  int last_hi = 0;
  always @(negedge clk) begin
    if (err) err_cnt <= err_cnt + 1;
    if (part_clk) hi_run <= hi_run + 1;
    else if (hi_run > 0) begin
      last_hi <= hi_run;
      hi_run  <= 0;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  int tx_rd = 0;
  task automatic check_tx(input string tag, input logic [7:0] exp);
    if (tx_rd >= tx_cnt) begin
      check({tag, "_missing"}, 32'(tx_cnt), 32'(tx_rd + 1));
    end else begin
      check(tag, 32'(tx_log[tx_rd % 256]), 32'(exp));
      tx_rd++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!idle && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!idle) check({tag, "_timeout"}, 32'(idle), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int         e0, s0, r0, t0, e1;
  logic [3:0] pat;
  logic [NPOS-1:0] pos_val;
  logic [7:0] exp_b;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_part_clk", 32'(part_clk), 32'd0);
    check("rst_part_rstn", 32'(part_rstn), 32'd0);
    check("rst_se_si_tm", {29'd0, part_se, part_si, part_tm}, 32'd0);
    check("rst_pis", 32'(part_pis), 32'd0);
    check("rst_idle_err", {30'd0, idle, err}, 32'd0);
    check("rst_state", 32'(dbg.state), 32'(BANNER));
    rst = 1'b0;

    // banner
    wait_idle("banner", 300);
    check_tx("banner_O", 8'h4F);
    check_tx("banner_K", 8'h4B);
    check_tx("banner_LF", 8'h0A);
    check("banner_rstn", 32'(part_rstn), 32'd1);
    check("banner_idle", 32'(idle), 32'd1);

    // set state 1011
    e0 = edge_cnt; s0 = se0_cnt; pat = 4'b1011;
    send_byte(CMD_SET_STATE, 2); send_byte(8'h00, 2); send_byte(8'h04, 2);
    for (int k = 0; k < 4; k++) send_byte(pat[3-k] ? ASCII_1 : ASCII_0, 20);
    wait_idle("s4", 400);
    check("s4_edges", 32'(edge_cnt - e0), 32'd4);
    check("s4_se_edges", 32'(se0_cnt - s0), 32'd0);
    for (int k = 0; k < 4; k++) check($sformatf("s4_si%0d", k), 32'(si_log[(e0 + k) % 1024]), 32'(pat[3-k]));
    check("s4_chain", 32'(sr), 32'hB);
    check("s4_se_after", 32'(part_se), 32'd0);
    check("s4_tm_eq_se", 32'(part_tm), 32'(part_se));

    // get state: rotates the chain
    send_byte(CMD_GET_STATE, 2); send_byte(8'h00, 2); send_byte(8'h04, 2);
    wait_idle("g4", 600);
    for (int k = 0; k < 4; k++) check_tx($sformatf("g4_b%0d", k), pat[3-k] ? ASCII_1 : ASCII_0);
    check("g4_chain", 32'(sr), 32'hB);

    // back-to-back bits go through the hold buffer
    e0 = edge_cnt; r0 = err_cnt;
    send_byte(CMD_SET_STATE, 2); send_byte(8'h00, 2); send_byte(8'h02, 2);
    send_byte(ASCII_0, 0); send_byte(ASCII_1, 0);
    wait_idle("sbuf", 300);
    check("sbuf_edges", 32'(edge_cnt - e0), 32'd2);
    check("sbuf_si0", 32'(si_log[e0 % 1024]), 32'd0);
    check("sbuf_si1", 32'(si_log[(e0 + 1) % 1024]), 32'd1);
    check("sbuf_err", 32'(err_cnt - r0), 32'd0);

    // set inputs 101 then get outputs x12
    send_byte(CMD_SET_INPUTS, 2); send_byte(8'h00, 2); send_byte(8'h03, 2);
    send_byte(ASCII_1, 2); send_byte(ASCII_0, 2); send_byte(ASCII_1, 2);
    wait_idle("i3", 100);
    check("i3_pis", 32'(part_pis), 32'h0005);
    pos_val = part_pos;
    send_byte(CMD_GET_OUTPUTS, 2); send_byte(8'h00, 2); send_byte(8'h0C, 2);
    wait_idle("o12", 1000);
    for (int k = 0; k < 12; k++) begin
      exp_b = (k < NPOS) ? (8'h30 | {7'd0, pos_val[k]}) : 8'h30;
      check_tx($sformatf("o12_b%0d", k), exp_b);
    end

    // execute 10 cycles
    e0 = edge_cnt; s0 = se0_cnt;
    send_byte(CMD_EXECUTE, 2); send_byte(8'h00, 2); send_byte(8'h0A, 2);
    wait_idle("e10", 600);
    check("e10_edges", 32'(edge_cnt - e0), 32'd10);
    check("e10_se0_edges", 32'(se0_cnt - s0), 32'd10);
    check("e10_high_clks", 32'(last_hi), 32'(CLK_DIV));

    // free run then pause
    e0 = edge_cnt;
    send_byte(CMD_FREE_RUN, 0);
    repeat (100) @(negedge clk);
    send_byte(CMD_PAUSE, 0);
    wait_idle("free", 60);
    e1 = edge_cnt;
    repeat (50) @(negedge clk);
    check("free_stopped", 32'(edge_cnt), 32'(e1));
    check("free_ran", 32'((e1 - e0) >= 9), 32'd1);
    check("free_idle", 32'(idle), 32'd1);

    // unknown command
    r0 = err_cnt; t0 = tx_cnt;
    send_byte(8'h78, 3);
    check("x_err", 32'(err_cnt - r0), 32'd1);
    check("x_no_tx", 32'(tx_cnt), 32'(t0));
    check("x_idle", 32'(idle), 32'd1);

    // bad bit inside set state
    r0 = err_cnt; e0 = edge_cnt;
    send_byte(CMD_SET_STATE, 2); send_byte(8'h00, 2); send_byte(8'h01, 2);
    send_byte(8'h37, 3); send_byte(ASCII_1, 0);
    wait_idle("sbad", 200);
    check("sbad_err", 32'(err_cnt - r0), 32'd1);
    check("sbad_edges", 32'(edge_cnt - e0), 32'd1);
    check("sbad_si", 32'(si_log[e0 % 1024]), 32'd1);

    // reset command
    e0 = edge_cnt;
    send_byte(CMD_RESET, 1);
    check("r_rstn_low", 32'(part_rstn), 32'd0);
    check("r_pis_clr", 32'(part_pis), 32'd0);
    wait_idle("r", 600);
    check("r_edges", 32'(edge_cnt - e0), 32'd2);
    check_tx("r_banner_O", 8'h4F);
    check_tx("r_banner_K", 8'h4B);
    check_tx("r_banner_LF", 8'h0A);
    check("r_rstn_high", 32'(part_rstn), 32'd1);

    // rst in the middle of execute
    send_byte(CMD_EXECUTE, 2); send_byte(8'h00, 2); send_byte(8'hFF, 30);
    check("mid_busy", 32'(idle), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_state", 32'(dbg.state), 32'(BANNER));
    check("mid_pclk", 32'(part_clk), 32'd0);
    check("mid_rstn", 32'(part_rstn), 32'd0);
    rst = 1'b0;
    wait_idle("mid", 300);
    check_tx("mid_banner_O", 8'h4F);
    check_tx("mid_banner_K", 8'h4B);
    check_tx("mid_banner_LF", 8'h0A);
    e1 = edge_cnt;
    repeat (30) @(negedge clk);
    check("mid_no_edges", 32'(edge_cnt), 32'(e1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tester_cmd_sequencer.md
Name: tester_cmd_sequencer

Overview:
- Command sequencer inside part_tester. It sits between uart_rx/uart_tx and the part-under-test pins (csoc).
- Parses single-byte ASCII commands and their 16-bit big-endian lengths.
- Sequences scan shifts, input application, output capture, counted execution and free-run of the part clock.
- Replies over UART with ASCII '0'/'1' bits and an "OK\n" banner.

Parameters:
- NPIS, 14, width of the primary-input register driven to the part (bit 0 = first bit sent).
- NPOS, 11, width of the part primary-output bus sampled.
- CLK_DIV, 4, clk cycles per half period of part_clk; legal range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_ready  in  1  uart_tx idle
- tx_start  out  1  request transmit of tx_data
- tx_data  out  8  byte to transmit
- part_clk  out  1  part clock
- part_rstn  out  1  part reset, active-low
- part_se  out  1  scan enable
- part_tm  out  1  test mode; always equal to part_se
- part_si  out  1  scan-in bit
- part_so  in  1  scan-out bit of part chain
- part_pis  out  NPIS  part primary inputs (data_i etc.)
- part_pos  in  NPOS  part primary outputs
- idle  out  1  high only in IDLE state
- err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset values (rst=1 at posedge clk):
  - tx_start=0, tx_data=0, part_clk=0, part_rstn=0, part_se=0, part_si=0, part_pis=0, idle=0, err=0.
  - State = BANNER.
- Part cycle (from part_clk_gen on start pulse):
  - part_clk low CLK_DIV clks, then high CLK_DIV clks, then done pulse.
  - Latency 2*CLK_DIV clks. part_clk idles low.
  - part_si/part_se stay stable for the whole cycle.
- TX handshake:
  - In a send state, wait for tx_ready=1.
  - Assert tx_start with tx_data stable until tx_ready falls, then deassert.
  - Wait for tx_ready=1 before the next action.
- BANNER: release part_rstn=1, send 'O','K',"\n" → IDLE.
- IDLE: idle=1. Action on rx_valid by byte:
  - 'r' → RESET.
  - 's','g','i','o','e' → LEN_HI, with the command latched.
  - 'f' → FREE.
  - 'p' → ignored silently.
  - Any other byte → err pulse, remain in IDLE.
- LEN_HI / LEN_LO: next two bytes form N[15:8], N[7:0]. If N==0 → IDLE directly after LEN_LO.
- 's' SET_STATE, repeated N times:
  - Wait for a byte. '1'/'0' sets part_si=1/0, part_se=1, and runs one part cycle.
  - Any other byte: err pulse, discarded, count not advanced.
  - Afterwards part_se=0 → IDLE.
- 'g' GET_STATE, repeated N times:
  - Send '0'+part_so (sampled at send start).
  - Then one part cycle with part_se=1, part_si=part_so (non-destructive rotation when N = chain length).
- 'i' SET_INPUTS, repeated N times for index k=0..N-1:
  - Byte '0'/'1' writes part_pis[k] immediately. k≥NPIS is accepted but ignored.
  - Bad byte: err pulse, discarded.
- 'o' GET_OUTPUTS:
  - Sample part_pos into a shadow register once, at LEN_LO completion.
  - Send '0'+shadow[k] for k=0..N-1. k≥NPOS sends '0'.
- 'e' EXECUTE: N part cycles with part_se=0. Incoming bytes are ignored.
- 'f' FREE:
  - Continuous part cycles with part_se=0.
  - On rx_valid with 'p', finish the current cycle → IDLE. Other bytes are ignored.
- 'r' RESET: part_rstn=0, part_pis=0 for 2 part cycles, part_rstn=1, then → BANNER.
- Counter: 16-bit down counter loaded with N. The last iteration is at count==1; there is no wrap.
- rx_valid arriving while a part cycle or TX is in progress in s/i: the byte is held in a 1-entry buffer. If a second byte arrives while the buffer is full, it is dropped and err pulses.
- rst mid-operation aborts everything in the same cycle and reissues the banner.

Decomposition:
- Package tester_pkg holds:
  - Command byte constants CMD_RESET="r", CMD_SET_STATE="s", CMD_GET_STATE="g", CMD_SET_INPUTS="i", CMD_GET_OUTPUTS="o", CMD_EXECUTE="e", CMD_FREE_RUN="f", CMD_PAUSE="p".
  - ASCII '0'/'1'.
  - State enum: BANNER, IDLE, LEN_HI, LEN_LO, SET_ST, GET_ST, SET_IN, GET_OUT, EXEC, FREE, RESET.
- One sub-module, part_clk_gen (parameter CLK_DIV; ports start, busy, done, part_clk).

Test Plan:
- Release rst → tx bytes 0x4F,0x4B,0x0A in order; part_rstn=1; idle=1.
- 's',0x00,0x04,"1011" → 4 part_clk rising edges with part_se=1 and part_si sequence 1,0,1,1; idle returns.
- Loop part_so to a 4-bit shift register preloaded 1011; 'g',0x00,0x04 → bytes '1','0','1','1'; register ends at 1011.
- 'i',0x00,0x03,"101" then 'o',0x00,0x0C with part_pos=11'h5A5 → part_pis[2:0]=3'b101; reply = bits 0..10 of 0x5A5 then '0'.
- 'e',0x00,0x0A → exactly 10 part_clk rising edges with part_se=0; 'f', wait 100 clk, 'p' → edges stop after the current cycle, idle=1.
- 'x' in IDLE → err pulse, no tx; 's',0x00,0x01,'7','1' → one err pulse, one shift with si=1; rst asserted mid-'e' → banner resent.
